noise_burst_mixer: RTL
======================

Name: noise_burst_mixer

Overview:
Parametrised multi-channel successor to the single-channel bang generator. Each channel produces noise scaled by either a direct volume level or a triggered, self-decaying envelope. Channels are summed and then smoothed by a first-order low-pass filter. The block runs on the system clock, advances once per 48 kHz sample strobe, and feeds the audio mixer with a signed sample.

Parameters:
CHANNELS, 2, number of independent noise voices (1..8, and no more than LFSR_W)
VOL_W, 4, width of each channel's volume/level
OUT_W, 16, output sample width, signed
LFSR_W, 17, noise shift register width (fixed taps x^17+x^14+1 when 17; otherwise a table selects the maximal-length taps)
NOISE_DIV, 4, sample strobes per LFSR step (1..255)
DECAY_DIV, 480, sample strobes per envelope decrement (1..65535)
FILT_SHIFT, 3, low-pass coefficient 2^-FILT_SHIFT; 0 means no filtering

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
clk_48KHz_en  in  1  one-cycle sample strobe
vol  in  CHANNELS*VOL_W  per-channel volume; channel c occupies bits [c*VOL_W +: VOL_W]
trig  in  CHANNELS  per-channel trigger level; the rising edge is used
mode  in  CHANNELS  per channel: 0 = direct level (level follows vol), 1 = triggered envelope
out  out  OUT_W  signed filtered mix

Behaviour:
- Single clock `clk`. Reset is asynchronous and active-high (`rst`); the polarity and synchronicity are fixed.
- Reset values:
  - LFSR = all ones.
  - Noise divider, decay divider, all levels, trig history, filter accumulator = 0.
  - out = 0.
- State changes only on edges where clk_48KHz_en = 1, with one exception: trig edge detection samples every clk and latches a pending flag per channel.
- Noise:
  - The divider counts strobes 0..NOISE_DIV-1; on wrap the LFSR shifts once.
  - If the LFSR ever reads all zero, it reloads all ones on the next step.
  - Channel c uses LFSR bit c: 1 gives +a_c, 0 gives -a_c.
- Level, mode 0: level_c <= vol_c on every strobe. Pending trig is cleared and ignored.
- Level, mode 1:
  - If pending trig is set: level_c <= vol_c, pending cleared.
  - Else, on a decay tick: level_c <= level_c - 1, saturating at 0.
  - Decay tick = the shared decay divider wrapping (0..DECAY_DIV-1).
  - Trigger and decay tick in the same strobe: trigger wins, no decrement that strobe.
  - A retrigger mid-decay reloads immediately.
- Amplitude:
  - a_c = level_c << S, where S = OUT_W-1-VOL_W-clog2(CHANNELS).
  - Elaboration error if S < 0.
  - The sum x = sum of ±a_c is guaranteed not to overflow OUT_W signed; no saturation logic.
- Filter:
  - Signed accumulator, width OUT_W+FILT_SHIFT+1.
  - On each strobe: acc <= acc + x - (acc >>> FILT_SHIFT).
  - out <= (acc_next >>> FILT_SHIFT).
  - x uses the levels and LFSR as they were before this strobe's update (one-sample pipeline lag).
  - With FILT_SHIFT = 0, out = x of the previous sample state.
- Latency: out is registered and changes only on strobe edges; it holds between strobes.
- Mode switch 1→0 mid-decay: the level snaps to vol at the next strobe.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous); the first strobe after release shifts nothing until the dividers wrap.

Test Plan:
1. Reset: hold rst and toggle clk and strobe → out = 0. Release, all vol = 0, mode = 0, strobe 100 times → out stays 0.
2. Direct level, defaults with FILT_SHIFT = 0: ch0 vol = 15, ch1 vol = 0, mode = 0, 64 strobes → out ∈ {+15360, -15360} only, and out changes sign only on strobes following an LFSR step (every 4th strobe).
3. Envelope decay, DECAY_DIV = 4, FILT_SHIFT = 0: ch0 mode 1, vol = 10, pulse trig one clk → |out| steps 10240, 9216, … down to 0. Level reaches 0 within 40 strobes of the trigger and out stays 0 thereafter.
4. Retrigger and priority: re-pulse trig while level = 3, aligned with a decay tick → next |a_0| = vol << 10 with no decrement. Mode switch to 0 mid-decay → level = vol at the next strobe.
5. Filter settling, FILT_SHIFT = 3, NOISE_DIV = 255 (noise held constant), mode 0, vol = 8 → out rises monotonically toward ±8192 and equals it exactly once settled, with no overshoot.
6. LFSR: run 131071 LFSR steps → the state returns to all ones exactly at the period and never hits zero. Asserting rst mid-run → out = 0 and LFSR = all ones asynchronously, before the next clk edge.

Source files
------------

// File: rtl/noise_burst_mixer.sv
// Multi-voice noise source: each channel is LFSR noise scaled by a direct or decaying-envelope level, summed, then low-pass filtered.
// Advances once per 48 kHz strobe; out is registered and lags the level/noise state by one sample.
module noise_burst_mixer #(
    parameter int CHANNELS   = 2,
    parameter int VOL_W      = 4,
    parameter int OUT_W      = 16,
    parameter int LFSR_W     = 17,
    parameter int NOISE_DIV  = 4,
    parameter int DECAY_DIV  = 480,
    parameter int FILT_SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_48KHz_en,
    input  logic [CHANNELS*VOL_W-1:0] vol,
    input  logic [CHANNELS-1:0]       trig,
    input  logic [CHANNELS-1:0]       mode,
    output logic [OUT_W-1:0]          out
);
    localparam int SHIFT  = OUT_W - 1 - VOL_W - $clog2(CHANNELS);
    localparam int ACC_W  = OUT_W + FILT_SHIFT + 1;
    localparam int NCNT_W = $clog2(NOISE_DIV + 1);
    localparam int DCNT_W = $clog2(DECAY_DIV + 1);

    // Maximal-length feedback taps, bit (t-1) set for each tap t.
    function automatic logic [31:0] tap_table(input int w);
        case (w)
            3:       tap_table = 32'h0000_0006;
            4:       tap_table = 32'h0000_000C;
            5:       tap_table = 32'h0000_0014;
            6:       tap_table = 32'h0000_0030;
            7:       tap_table = 32'h0000_0060;
            8:       tap_table = 32'h0000_00B8;
            9:       tap_table = 32'h0000_0110;
            10:      tap_table = 32'h0000_0240;
            11:      tap_table = 32'h0000_0500;
            12:      tap_table = 32'h0000_0829;
            13:      tap_table = 32'h0000_100D;
            14:      tap_table = 32'h0000_2015;
            15:      tap_table = 32'h0000_6000;
            16:      tap_table = 32'h0000_D008;
            17:      tap_table = 32'h0001_2000;
            18:      tap_table = 32'h0002_0400;
            19:      tap_table = 32'h0004_0023;
            20:      tap_table = 32'h0009_0000;
            21:      tap_table = 32'h0014_0000;
            22:      tap_table = 32'h0030_0000;
            23:      tap_table = 32'h0042_0000;
            24:      tap_table = 32'h00E1_0000;
            default: tap_table = 32'h0000_0000;
        endcase
    endfunction

    localparam logic [31:0] TAPS = tap_table(LFSR_W);

    if (SHIFT < 0) begin : g_bad_shift
        $error("noise_burst_mixer: OUT_W too narrow for VOL_W and CHANNELS");
    end
    if (CHANNELS < 1 || CHANNELS > 8 || CHANNELS > LFSR_W) begin : g_bad_channels
        $error("noise_burst_mixer: CHANNELS out of range");
    end
    if (TAPS == 32'h0) begin : g_bad_lfsr
        $error("noise_burst_mixer: no tap set for this LFSR_W");
    end
    if (NOISE_DIV < 1 || NOISE_DIV > 255 || DECAY_DIV < 1 || DECAY_DIV > 65535) begin : g_bad_div
        $error("noise_burst_mixer: divider out of range");
    end

    function automatic logic signed [OUT_W-1:0] amp_of(input logic [VOL_W-1:0] lvl);
        amp_of = $signed({{(OUT_W-VOL_W){1'b0}}, lvl} << SHIFT);
    endfunction

    logic [LFSR_W-1:0]        lfsr;
    logic [LFSR_W-1:0]        lfsr_step;
    logic [NCNT_W-1:0]        noise_cnt;
    logic [DCNT_W-1:0]        decay_cnt;
    logic                     noise_wrap;
    logic                     decay_tick;
    logic [VOL_W-1:0]         level [CHANNELS];
    logic [CHANNELS-1:0]      trig_prev;
    logic [CHANNELS-1:0]      pending;
    logic [CHANNELS-1:0]      trig_evt;
    logic signed [OUT_W-1:0]  x;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;

    assign noise_wrap = (noise_cnt == NCNT_W'(NOISE_DIV - 1));
    assign decay_tick = (decay_cnt == DCNT_W'(DECAY_DIV - 1));
    // A rising edge on the same clock as a strobe is seen by that strobe.
    assign trig_evt   = pending | (trig & ~trig_prev);

    always_comb begin
        lfsr_step = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS[LFSR_W-1:0])};
        if (lfsr == '0) begin
            lfsr_step = '1;
        end
    end

    always_comb begin
        x = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (lfsr[c]) begin
                x = x + amp_of(level[c]);
            end else begin
                x = x - amp_of(level[c]);
            end
        end
    end

    assign acc_next = acc + $signed({{(FILT_SHIFT+1){x[OUT_W-1]}}, x}) - (acc >>> FILT_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_prev <= '0;
            pending   <= '0;
        end else begin
            trig_prev <= trig;
            pending   <= clk_48KHz_en ? '0 : trig_evt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr      <= '1;
            noise_cnt <= '0;
            decay_cnt <= '0;
            acc       <= '0;
            out       <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                level[c] <= '0;
            end
        end else if (clk_48KHz_en) begin
            noise_cnt <= noise_wrap ? '0 : noise_cnt + NCNT_W'(1);
            decay_cnt <= decay_tick ? '0 : decay_cnt + DCNT_W'(1);
            if (noise_wrap) begin
                lfsr <= lfsr_step;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (!mode[c] || trig_evt[c]) begin
                    level[c] <= vol[c*VOL_W +: VOL_W];
                end else if (decay_tick && level[c] != '0) begin
                    level[c] <= level[c] - VOL_W'(1);
                end
            end
            acc <= acc_next;
            out <= acc_next[OUT_W+FILT_SHIFT-1:FILT_SHIFT];
        end
    end
endmodule
